queue_sensor_decoder: RTL and testbench
=======================================

QUEUE_SENSOR_DECODER -- requirements
Module: queue_sensor_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles needed before a filtered sensor changes (used only with DEBOUNCE_EN).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sensor_a  input  1  outer beam-break sensor, asynchronous, 1 = blocked.
REQ-005 SHALL have port sensor_b  input  1  inner beam-break sensor, asynchronous, 1 = blocked.
REQ-006 SHALL have port up  output  1  one-cycle pulse per completed client entry; drives the occupancy counter's up input.
REQ-007 SHALL have port down  output  1  one-cycle pulse per completed client exit; drives the occupancy counter's down input.
REQ-008 SHALL have port err  output  1  one-cycle pulse on an illegal sensor sequence.
REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 Each sensor SHALL pass through a 2-flop synchronizer; ab below denotes the conditioned pair {a,b}.
REQ-011 The FSM SHALL have states IDLE, ENT1, ENT2, ENT3, EXT1, EXT2, EXT3 and WAIT_CLR.
REQ-012 IDLE: ab=10 -> ENT1; 01 -> EXT1; 11 -> WAIT_CLR with err; 00 -> stay.
REQ-013 ENT1: 10 stay; 11 -> ENT2; 00 -> IDLE (abort, no pulse); 01 -> WAIT_CLR with err.
REQ-014 ENT2: 11 stay; 01 -> ENT3; 10 -> ENT1; 00 -> WAIT_CLR with err.
REQ-015 ENT3: 01 stay; 00 -> IDLE with up; 11 -> ENT2; 10 -> WAIT_CLR with err.
REQ-016 EXT1/EXT2/EXT3 SHALL mirror ENT1/ENT2/ENT3 with a and b swapped, and down in place of up.
REQ-017 WAIT_CLR: 00 -> IDLE; any other ab -> stay, with no further err.
REQ-018 up, down and err SHALL be registered outputs, asserted for exactly one cycle in the cycle after the causing transition.
REQ-019 up and down SHALL never be asserted in the same cycle.
REQ-020 Without debounce, up/down SHALL assert 3 cycles after the raw sensor edge that completes the sequence (2 sync + 1 output register).
REQ-021 A full sequence held in any state for an arbitrary time SHALL still produce exactly one pulse.

Reset
REQ-022 While reset is high at a clk edge: state = IDLE; synchronizer flops = 0; debounce counters = 0 and filtered values = 0; up = down = err = busy = 0.
REQ-023 Reset asserted mid-sequence SHALL abort the sequence with no pulse; after release, the FSM SHALL start from IDLE using the current ab.

Configuration
REQ-024 With macro QUEUE_SENSOR_DEBOUNCE_EN defined, each synchronized sensor SHALL change its filtered value only after DEBOUNCE_CYCLES consecutive cycles at the new level; any glitch restarts the count.
REQ-025 This adds DEBOUNCE_CYCLES cycles to the REQ-020 latency.
REQ-026 Without QUEUE_SENSOR_DEBOUNCE_EN, the filtered value SHALL equal the synchronized value and no counter logic SHALL exist.

Structure
REQ-027 Shared package queue_pkg SHALL hold the FSM state typedef (3-bit enum) and the default DEBOUNCE_CYCLES constant.
REQ-028 Sub-module sensor_conditioner (synchronizer + optional debounce) SHALL be instantiated once per sensor.

Verification
REQ-029 Entry: ab 00->10->11->01->00, each held 5 cycles, no debounce -> exactly one up pulse 3 cycles after the final edge; down = err = 0.
REQ-030 Exit: ab 00->01->11->10->00 -> exactly one down pulse; up = 0; busy high from EXT1 through the pulse cycle.
REQ-031 Abort: ab 00->10->11->10->00 -> no up, no down, no err; FSM ends in IDLE.
REQ-032 Illegal: ab 00->11 held 10 cycles, then 00 -> one err pulse only; IDLE after 00.
REQ-033 Reset: reset asserted while in ENT3 with ab=01, then ab->00 after release -> no up pulse.
REQ-034 With QUEUE_SENSOR_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: 2-cycle glitch on sensor_a from IDLE -> FSM stays IDLE; full entry with 6-cycle holds -> one up pulse 7 cycles after the final edge.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared types for the queue sensor decoder: FSM state encoding, default
// debounce length and the pure next-state function used by the top.
package queue_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ENT1     = 3'd1,
      ENT2     = 3'd2,
      ENT3     = 3'd3,
      EXT1     = 3'd4,
      EXT2     = 3'd5,
      EXT3     = 3'd6,
      WAIT_CLR = 3'd7
   } state_t;

   typedef struct packed {
      state_t next;
      logic   up;
      logic   down;
      logic   err;
   } fsm_out_t;

   // Exit states walk the same ladder as entry states with the sensors
   // swapped, so both directions share one set of rules on {p,q}.
   function automatic fsm_out_t fsm_step(input state_t s, input logic a, input logic b);
      fsm_out_t   o;
      logic       ext;
      logic [1:0] pq;
      state_t     s1, s2, s3;
      ext    = (s == EXT1) || (s == EXT2) || (s == EXT3);
      pq     = ext ? {b, a} : {a, b};
      s1     = ext ? EXT1 : ENT1;
      s2     = ext ? EXT2 : ENT2;
      s3     = ext ? EXT3 : ENT3;
      o.next = s;
      o.up   = 1'b0;
      o.down = 1'b0;
      o.err  = 1'b0;
      case (s)
         IDLE: begin
            case ({a, b})
               2'b10:   o.next = ENT1;
               2'b01:   o.next = EXT1;
               2'b11: begin
                  o.next = WAIT_CLR;
                  o.err  = 1'b1;
               end
               default: o.next = IDLE;
            endcase
         end
         ENT1, EXT1: begin
            case (pq)
               2'b11:   o.next = s2;
               2'b00:   o.next = IDLE;
               2'b01: begin
                  o.next = WAIT_CLR;
                  o.err  = 1'b1;
               end
               default: o.next = s;
            endcase
         end
         ENT2, EXT2: begin
            case (pq)
               2'b01:   o.next = s3;
               2'b10:   o.next = s1;
               2'b00: begin
                  o.next = WAIT_CLR;
                  o.err  = 1'b1;
               end
               default: o.next = s;
            endcase
         end
         ENT3, EXT3: begin
            case (pq)
               2'b00: begin
                  o.next = IDLE;
                  o.up   = ~ext;
                  o.down = ext;
               end
               2'b11:   o.next = s2;
               2'b10: begin
                  o.next = WAIT_CLR;
                  o.err  = 1'b1;
               end
               default: o.next = s;
            endcase
         end
         default: o.next = ({a, b} == 2'b00) ? IDLE : WAIT_CLR;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sensor_conditioner.sv
// Two-flop synchronizer for one beam sensor, with an optional stability
// filter enabled by QUEUE_SENSOR_DEBOUNCE_EN.
module sensor_conditioner
   import queue_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filt
);

   logic meta, sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

`ifdef QUEUE_SENSOR_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

   logic [CW-1:0] cnt;

   // cnt counts consecutive cycles at a level different from filt; the
   // flip happens on the DEBOUNCE_CYCLES-th such cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         filt <= 1'b0;
      end else if (sync == filt) begin
         cnt  <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         cnt  <= '0;
         filt <= sync;
      end else begin
         cnt  <= cnt + 1'b1;
      end
   end
`else
   assign filt = sync;
`endif

endmodule

// File: rtl/queue_sensor_decoder.sv
// Decodes a two-beam doorway into entry/exit/error pulses; the debounce
// stage is built only when QUEUE_SENSOR_DEBOUNCE_EN is defined.
module queue_sensor_decoder
   import queue_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic sensor_a,
   input  logic sensor_b,
   output logic up,
   output logic down,
   output logic err,
   output logic busy
);

   logic     a_f, b_f;
   state_t   state;
   fsm_out_t nx;

   sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_a (
      .clk   (clk),
      .reset (reset),
      .raw   (sensor_a),
      .filt  (a_f)
   );

   sensor_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_b (
      .clk   (clk),
      .reset (reset),
      .raw   (sensor_b),
      .filt  (b_f)
   );

   always_comb nx = fsm_step(state, a_f, b_f);

   // busy stays up through the completing pulse so a consumer sees one
   // contiguous window per transaction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         up    <= 1'b0;
         down  <= 1'b0;
         err   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= nx.next;
         up    <= nx.up;
         down  <= nx.down;
         err   <= nx.err;
         busy  <= (nx.next != IDLE) | nx.up | nx.down;
      end
   end

endmodule

// File: tb/tb_queue_sensor_decoder.sv
// Bench for queue_sensor_decoder: directed table, latency/reset sequences and
// random traffic against a ladder-position reference model.
module tb_queue_sensor_decoder;

   localparam int DEB = 4;
`ifdef QUEUE_SENSOR_DEBOUNCE_EN
   localparam int LAT  = 3 + DEB;
`else
   localparam int LAT  = 3;
`endif
   localparam int HOLD = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sensor_a = 1'b0, sensor_b = 1'b0;
   logic up, down, err, busy;

   int checks = 0;
   int errors = 0;
   int n_up = 0, n_down = 0, n_err = 0, n_busy = 0;

   queue_sensor_decoder #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk      (clk),
      .reset    (reset),
      .sensor_a (sensor_a),
      .sensor_b (sensor_b),
      .up       (up),
      .down     (down),
      .err      (err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 entering, 2 exiting, 3 waiting for clear.
   // pos is the rung on the ladder 10 -> 11 -> 01 seen from the walking
   // direction; moving more than one rung or leaving from the middle is illegal.
   int   m_mode = 0, m_pos = 0, m_q = 0;
   logic m_s1a = 0, m_s1b = 0, m_s2a = 0, m_s2b = 0;
   logic m_up = 0, m_down = 0, m_err = 0, m_busy = 0;
   logic [1:0] m_ab, m_pq;
`ifdef QUEUE_SENSOR_DEBOUNCE_EN
   logic m_fa = 0, m_fb = 0;
   int   m_ca = 0, m_cb = 0;
`endif

   always @(posedge clk) begin
      if (reset) begin
         m_mode = 0; m_pos = 0;
         m_s1a = 0; m_s1b = 0; m_s2a = 0; m_s2b = 0;
         m_up = 0; m_down = 0; m_err = 0; m_busy = 0;
`ifdef QUEUE_SENSOR_DEBOUNCE_EN
         m_fa = 0; m_fb = 0; m_ca = 0; m_cb = 0;
`endif
      end else begin
`ifdef QUEUE_SENSOR_DEBOUNCE_EN
         m_ab = {m_fa, m_fb};
`else
         m_ab = {m_s2a, m_s2b};
`endif
         m_up = 0; m_down = 0; m_err = 0;
         case (m_mode)
            0: begin
               if (m_ab == 2'b10) begin m_mode = 1; m_pos = 0; end
               else if (m_ab == 2'b01) begin m_mode = 2; m_pos = 0; end
               else if (m_ab == 2'b11) begin m_mode = 3; m_err = 1; end
            end
            1, 2: begin
               m_pq = (m_mode == 1) ? m_ab : {m_ab[0], m_ab[1]};
               if (m_pq == 2'b00) begin
                  if (m_pos == 0) m_mode = 0;
                  else if (m_pos == 2) begin
                     m_up = (m_mode == 1); m_down = (m_mode == 2); m_mode = 0;
                  end else begin m_mode = 3; m_err = 1; end
               end else begin
                  m_q = (m_pq == 2'b10) ? 0 : (m_pq == 2'b11) ? 1 : 2;
                  if (m_q - m_pos > 1 || m_pos - m_q > 1) begin m_mode = 3; m_err = 1; end
                  else m_pos = m_q;
               end
            end
            default: if (m_ab == 2'b00) m_mode = 0;
         endcase
         m_busy = (m_mode != 0) || m_up || m_down;
`ifdef QUEUE_SENSOR_DEBOUNCE_EN
         if (m_s2a == m_fa) m_ca = 0;
         else begin m_ca++; if (m_ca == DEB) begin m_fa = m_s2a; m_ca = 0; end end
         if (m_s2b == m_fb) m_cb = 0;
         else begin m_cb++; if (m_cb == DEB) begin m_fb = m_s2b; m_cb = 0; end end
`endif
         m_s2a = m_s1a; m_s2b = m_s1b;
         m_s1a = sensor_a; m_s1b = sensor_b;
      end
   end

   always @(negedge clk) begin
      chk("up_vs_model", int'(up), int'(m_up));
      chk("down_vs_model", int'(down), int'(m_down));
      chk("err_vs_model", int'(err), int'(m_err));
      chk("busy_vs_model", int'(busy), int'(m_busy));
      chk("up_down_exclusive", int'(up & down), 0);
      if (up) n_up++;
      if (down) n_down++;
      if (err) n_err++;
      if (busy) n_busy++;
   end

   task automatic hold(input logic [1:0] v, input int n);
      sensor_a = v[1];
      sensor_b = v[0];
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      hold(2'b00, 3);
      reset = 1'b0;
      n_up = 0; n_down = 0; n_err = 0; n_busy = 0;
   endtask

   typedef struct {
      string       name;
      logic [11:0] seq;
      int          e_up;
      int          e_down;
      int          e_err;
   } vec_t;

   vec_t tbl [9];
   int   lat;
   logic [1:0] v, walk [4];

   initial begin
      tbl[0] = '{"entry",        12'b00_10_11_01_00_00, 1, 0, 0};
      tbl[1] = '{"exit",         12'b00_01_11_10_00_00, 0, 1, 0};
      tbl[2] = '{"abort",        12'b00_10_11_10_00_00, 0, 0, 0};
      tbl[3] = '{"illegal11",    12'b00_11_11_00_00_00, 0, 0, 1};
      tbl[4] = '{"entry_wobble", 12'b10_11_10_11_01_00, 1, 0, 0};
      tbl[5] = '{"ent_skip",     12'b00_10_01_00_00_00, 0, 0, 1};
      tbl[6] = '{"ent3_back",    12'b10_11_01_11_01_00, 1, 0, 0};
      tbl[7] = '{"ent2_drop",    12'b00_10_11_00_00_00, 0, 0, 1};
      tbl[8] = '{"exit_abort",   12'b00_01_00_00_00_00, 0, 0, 0};
      walk[0] = 2'b10; walk[1] = 2'b11; walk[2] = 2'b01; walk[3] = 2'b00;

      @(posedge clk);
      #1;
      do_reset();
      chk("reset_up", int'(up), 0);
      chk("reset_down", int'(down), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_busy", int'(busy), 0);

      foreach (tbl[i]) begin
         do_reset();
         for (int k = 0; k < 6; k++) hold(tbl[i].seq[11 - 2 * k -: 2], HOLD);
         hold(2'b00, LAT + 6);
         chk({tbl[i].name, "_up"}, n_up, tbl[i].e_up);
         chk({tbl[i].name, "_down"}, n_down, tbl[i].e_down);
         chk({tbl[i].name, "_err"}, n_err, tbl[i].e_err);
         chk({tbl[i].name, "_idle"}, int'(busy), 0);
      end

      // Latency from the raw edge that completes an entry.
      do_reset();
      hold(2'b10, HOLD); hold(2'b11, HOLD); hold(2'b01, HOLD);
      sensor_a = 1'b0; sensor_b = 1'b0;
      lat = -1;
      for (int k = 0; k < LAT + 8; k++) begin
         @(negedge clk);
         if (up && lat < 0) lat = k;
      end
      chk("entry_latency", lat, LAT);
      chk("entry_latency_count", n_up, 1);

      // Reset while in ENT3 must drop the pending entry.
      do_reset();
      hold(2'b10, HOLD); hold(2'b11, HOLD); hold(2'b01, HOLD + LAT);
      chk("ent3_busy_before_reset", int'(busy), 1);
      reset = 1'b1;
      hold(2'b01, 2);
      reset = 1'b0;
      hold(2'b00, LAT + 10);
      chk("reset_abort_up", n_up, 0);
      chk("reset_abort_idle", int'(busy), 0);

`ifdef QUEUE_SENSOR_DEBOUNCE_EN
      do_reset();
      hold(2'b10, 2);
      hold(2'b00, LAT + 8);
      chk("glitch_busy_cycles", n_busy, 0);
      chk("glitch_err", n_err, 0);
`endif

      // Random traffic, half of it legal walks in either direction.
      do_reset();
      for (int s = 0; s < 250; s++) begin
         if ($urandom_range(0, 29) == 0) begin
            reset = 1'b1;
            hold({sensor_a, sensor_b}, int'($urandom_range(1, 3)));
            reset = 1'b0;
         end
         if ($urandom_range(0, 1) == 1) begin
            bit dir;
            dir = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
               v = dir ? {walk[k][0], walk[k][1]} : walk[k];
               hold(v, int'($urandom_range(1, 7)));
            end
         end else begin
            hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 7)));
         end
      end
      hold(2'b00, LAT + 6);
      chk("random_end_idle", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
